// File: rtl/alu_16_regfile_ctrl_if.sv
// Instruction handshake bundle for alu_16_regfile_ctrl: {op, rd, rs1, rs2} offered under valid/ready.
interface alu_16_regfile_ctrl_if #(
  parameter int AW = 2
) ();
  logic                  instr_valid;
  logic                  instr_ready;
  logic [2+3*AW-1:0]     instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/alu_16_regfile_ctrl.sv
// Operand-fetch / write-back stage around a combinational alu_16: register file,
// registered operands, one-cycle-later capture of the ALU result and flags.
module alu_16_regfile_ctrl #(
  parameter int WIDTH = 16,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alu_16_regfile_ctrl_if.slave instr_bus,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic [1:0]           alu_op,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic [WIDTH-1:0]     alu_o,
  input  logic                 alu_cout,
  output logic                 result_valid,
  output logic [WIDTH-1:0]     result,
  output logic                 carry_flag,
  output logic                 zero_flag,
  output logic                 wr_conflict
);
  localparam int NREGS = 2 ** AW;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             write_back;
  logic [AW-1:0]    rd_q;
  logic [WIDTH-1:0] regs [NREGS];

  logic [1:0]    dec_op;
  logic [AW-1:0] dec_rd;
  logic [AW-1:0] dec_rs1;
  logic [AW-1:0] dec_rs2;

  assign dec_op  = instr_bus.instr[2+3*AW-1 -: 2];
  assign dec_rd  = instr_bus.instr[3*AW-1 -: AW];
  assign dec_rs1 = instr_bus.instr[2*AW-1 -: AW];
  assign dec_rs2 = instr_bus.instr[AW-1:0];

  assign rd_data = regs[rd_addr];

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_bus.instr_ready = (state == IDLE) && reset_n;
    accept                = instr_bus.instr_valid && instr_bus.instr_ready;
    write_back            = (state == EXEC);
  end

  // Operands sample the array before this edge's writes; on a rd collision the
  // write-back is placed last so it overrides the host write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rd_q         <= '0;
      result       <= '0;
      carry_flag   <= 1'b0;
      zero_flag    <= 1'b0;
      result_valid <= 1'b0;
      wr_conflict  <= 1'b0;
    end else begin
      result_valid <= write_back;
      wr_conflict  <= write_back && wr_en && (wr_addr == rd_q);
      if (accept) begin
        alu_op <= dec_op;
        alu_a  <= regs[dec_rs1];
        alu_b  <= regs[dec_rs2];
        rd_q   <= dec_rd;
      end
      if (wr_en) regs[wr_addr] <= wr_data;
      if (write_back) begin
        regs[rd_q] <= alu_o;
        result     <= alu_o;
        carry_flag <= alu_cout;
        zero_flag  <= (alu_o == '0);
      end
    end
  end
endmodule

// File: tb/tb_alu_16_regfile_ctrl.sv
// Directed bench for alu_16_regfile_ctrl with a behavioural alu_16 (00 add, 01 sub, 10 and, 11 or).
module tb_alu_16_regfile_ctrl;
  localparam int WIDTH = 16;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_o;
  logic             alu_cout;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic             carry_flag;
  logic             zero_flag;
  logic             wr_conflict;

  int total = 0;
  int bad   = 0;

  alu_16_regfile_ctrl_if #(.AW(AW)) instr_bus ();

  alu_16_regfile_ctrl #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr_bus    (instr_bus),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_o        (alu_o),
    .alu_cout     (alu_cout),
    .result_valid (result_valid),
    .result       (result),
    .carry_flag   (carry_flag),
    .zero_flag    (zero_flag),
    .wr_conflict  (wr_conflict)
  );

  always #5 clk = ~clk;

  always_comb begin
    {alu_cout, alu_o} = '0;
    case (alu_op)
      2'b00: {alu_cout, alu_o} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: {alu_cout, alu_o} = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10: alu_o = alu_a & alu_b;
      default: alu_o = alu_a | alu_b;
    endcase
  end

  task automatic host_write(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (instr_bus.instr_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 0", instr_bus.instr_ready); end
    total++; if ({result_valid, wr_conflict, carry_flag, zero_flag} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_flags: got %b expected 0000", {result_valid, wr_conflict, carry_flag, zero_flag}); end
    total++; if ({result, alu_a, alu_b, alu_op} !== '0) begin bad++; $display("[TB] FAIL reset_data: got %h/%h/%h/%h expected 0", result, alu_a, alu_b, alu_op); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = AW'(i); #1;
      total++; if (rd_data !== 16'h0000) begin bad++; $display("[TB] FAIL reset_reg%0d: got %h expected 0000", i, rd_data); end
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (instr_bus.instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_ready: got %b expected 1", instr_bus.instr_ready); end
  endtask

  task automatic test_carry_zero();
    host_write(2'd0, 16'hffff);
    host_write(2'd1, 16'h0001);
    instr_bus.instr_valid = 1'b1; instr_bus.instr = {2'b00, 2'd2, 2'd0, 2'd1};
    @(negedge clk);
    instr_bus.instr_valid = 1'b0;
    total++; if ({alu_a, alu_b} !== {16'hffff, 16'h0001}) begin bad++; $display("[TB] FAIL t1_operands: got %h %h expected ffff 0001", alu_a, alu_b); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("[TB] FAIL t1_early_valid: got %b expected 0", result_valid); end
    @(negedge clk);
    total++; if (result_valid !== 1'b1) begin bad++; $display("[TB] FAIL t1_valid: got %b expected 1", result_valid); end
    total++; if ({result, carry_flag, zero_flag} !== {16'h0000, 1'b1, 1'b1}) begin bad++; $display("[TB] FAIL t1_result: got %h c=%b z=%b expected 0000 c=1 z=1", result, carry_flag, zero_flag); end
    rd_addr = 2'd2; #1;
    total++; if (rd_data !== 16'h0000) begin bad++; $display("[TB] FAIL t1_r2: got %h expected 0000", rd_data); end
    @(negedge clk);
    total++; if (result_valid !== 1'b0) begin bad++; $display("[TB] FAIL t1_pulse_len: got %b expected 0", result_valid); end
  endtask

  task automatic test_rd_eq_rs1();
    host_write(2'd0, 16'h0001);
    host_write(2'd1, 16'h7fff);
    instr_bus.instr_valid = 1'b1; instr_bus.instr = {2'b00, 2'd0, 2'd0, 2'd1};
    @(negedge clk);
    instr_bus.instr_valid = 1'b0;
    total++; if (instr_bus.instr_ready !== 1'b0) begin bad++; $display("[TB] FAIL t2_ready_low: got %b expected 0", instr_bus.instr_ready); end
    @(negedge clk);
    total++; if (instr_bus.instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL t2_ready_back: got %b expected 1", instr_bus.instr_ready); end
    total++; if ({result_valid, result, carry_flag, zero_flag} !== {1'b1, 16'h8000, 1'b0, 1'b0}) begin bad++; $display("[TB] FAIL t2_result: got v=%b %h c=%b z=%b expected v=1 8000 c=0 z=0", result_valid, result, carry_flag, zero_flag); end
    rd_addr = 2'd0; #1;
    total++; if (rd_data !== 16'h8000) begin bad++; $display("[TB] FAIL t2_r0: got %h expected 8000", rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  prog [3];
    logic [15:0] exp_res [3];
    int idx, pulses, accepts, will_accept;
    int acc_cyc [3];
    prog[0] = {2'b00, 2'd3, 2'd0, 2'd1}; exp_res[0] = 16'h0003;
    prog[1] = {2'b00, 2'd2, 2'd3, 2'd0}; exp_res[1] = 16'h0004;
    prog[2] = {2'b00, 2'd1, 2'd2, 2'd2}; exp_res[2] = 16'h0008;
    host_write(2'd0, 16'h0001);
    host_write(2'd1, 16'h0002);
    host_write(2'd2, 16'h0003);
    host_write(2'd3, 16'h0000);
    idx = 0; pulses = 0; accepts = 0;
    instr_bus.instr_valid = 1'b1; instr_bus.instr = prog[0];
    will_accept = int'(instr_bus.instr_ready);
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (will_accept != 0) begin
        if (accepts < 3) acc_cyc[accepts] = cyc;
        accepts++;
        idx++;
        if (idx >= 3) instr_bus.instr_valid = 1'b0;
        else          instr_bus.instr = prog[idx];
      end
      if (result_valid === 1'b1) begin
        if (pulses < 3) begin
          total++; if (result !== exp_res[pulses]) begin bad++; $display("[TB] FAIL t3_result%0d: got %h expected %h", pulses, result, exp_res[pulses]); end
        end
        pulses++;
      end
      will_accept = int'(instr_bus.instr_valid && instr_bus.instr_ready);
    end
    total++; if (accepts != 3) begin bad++; $display("[TB] FAIL t3_accepts: got %0d expected 3", accepts); end
    total++; if (pulses != 3) begin bad++; $display("[TB] FAIL t3_pulses: got %0d expected 3", pulses); end
    if (accepts == 3) begin
      total++; if ((acc_cyc[1] - acc_cyc[0] != 2) || (acc_cyc[2] - acc_cyc[1] != 2)) begin bad++; $display("[TB] FAIL t3_spacing: got %0d,%0d,%0d expected every 2 cycles", acc_cyc[0], acc_cyc[1], acc_cyc[2]); end
    end
    rd_addr = 2'd1; #1;
    total++; if (rd_data !== 16'h0008) begin bad++; $display("[TB] FAIL t3_r1: got %h expected 0008", rd_data); end
  endtask

  task automatic test_wr_conflict();
    // regs now: r0=1 r1=8 r2=4 r3=3
    instr_bus.instr_valid = 1'b1; instr_bus.instr = {2'b00, 2'd3, 2'd0, 2'd1};
    @(negedge clk);
    instr_bus.instr_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 16'h1234;
    @(negedge clk);
    wr_en = 1'b0;
    total++; if (wr_conflict !== 1'b1) begin bad++; $display("[TB] FAIL t4_conflict: got %b expected 1", wr_conflict); end
    rd_addr = 2'd3; #1;
    total++; if (rd_data !== 16'h0009) begin bad++; $display("[TB] FAIL t4_r3: got %h expected 0009", rd_data); end
    @(negedge clk);
    total++; if (wr_conflict !== 1'b0) begin bad++; $display("[TB] FAIL t4_conflict_len: got %b expected 0", wr_conflict); end
    instr_bus.instr_valid = 1'b1; instr_bus.instr = {2'b00, 2'd2, 2'd0, 2'd0};
    @(negedge clk);
    instr_bus.instr_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h5a5a;
    @(negedge clk);
    wr_en = 1'b0;
    total++; if (wr_conflict !== 1'b0) begin bad++; $display("[TB] FAIL t4_no_conflict: got %b expected 0", wr_conflict); end
    rd_addr = 2'd1; #1;
    total++; if (rd_data !== 16'h5a5a) begin bad++; $display("[TB] FAIL t4_r1: got %h expected 5a5a", rd_data); end
    rd_addr = 2'd2; #1;
    total++; if (rd_data !== 16'h0002) begin bad++; $display("[TB] FAIL t4_r2: got %h expected 0002", rd_data); end
  endtask

  task automatic test_no_bypass();
    instr_bus.instr_valid = 1'b1; instr_bus.instr = {2'b00, 2'd3, 2'd0, 2'd1};
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'haa55;
    @(negedge clk);
    instr_bus.instr_valid = 1'b0; wr_en = 1'b0;
    total++; if (alu_a !== 16'h0001) begin bad++; $display("[TB] FAIL t5_old_rs1: got %h expected 0001", alu_a); end
    rd_addr = 2'd0; #1;
    total++; if (rd_data !== 16'haa55) begin bad++; $display("[TB] FAIL t5_rd_data: got %h expected aa55", rd_data); end
    @(negedge clk);
    total++; if ({result_valid, result} !== {1'b1, 16'h5a5b}) begin bad++; $display("[TB] FAIL t5_result: got v=%b %h expected v=1 5a5b", result_valid, result); end
  endtask

  task automatic test_reset_in_exec();
    instr_bus.instr_valid = 1'b1; instr_bus.instr = {2'b00, 2'd2, 2'd0, 2'd1};
    @(negedge clk);
    instr_bus.instr_valid = 1'b0;
    total++; if (instr_bus.instr_ready !== 1'b0) begin bad++; $display("[TB] FAIL t6_in_exec: got ready=%b expected 0", instr_bus.instr_ready); end
    reset_n = 1'b0;
    @(negedge clk);
    total++; if ({result_valid, carry_flag, zero_flag, wr_conflict} !== 4'b0000) begin bad++; $display("[TB] FAIL t6_flags: got %b expected 0000", {result_valid, carry_flag, zero_flag, wr_conflict}); end
    total++; if ({result, alu_a, alu_b, alu_op} !== '0) begin bad++; $display("[TB] FAIL t6_data: got %h/%h/%h/%h expected 0", result, alu_a, alu_b, alu_op); end
    rd_addr = 2'd2; #1;
    total++; if (rd_data !== 16'h0000) begin bad++; $display("[TB] FAIL t6_r2: got %h expected 0000", rd_data); end
    reset_n = 1'b1;
    @(negedge clk);
    total++; if ({instr_bus.instr_ready, result_valid} !== 2'b10) begin bad++; $display("[TB] FAIL t6_release: got ready=%b valid=%b expected 1 0", instr_bus.instr_ready, result_valid); end
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    instr_bus.instr_valid = 1'b0; instr_bus.instr = '0;
    test_reset();
    test_carry_zero();
    test_rd_eq_rs1();
    test_back_to_back();
    test_wr_conflict();
    test_no_bypass();
    test_reset_in_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
